tqv_stage_loader: RTL and testbench

- Bus initiator for the TinyQV peripheral register interface; drives the address/data_in/data_write_n/data_read_n side of a sprite/video peripheral and consumes its data_out/data_ready/user_interrupt.
- Holds a small buffer of 32-bit object-table words pushed by a producer.
- On each peripheral interrupt it writes the whole table into the peripheral's staging region, sets STAGING_READY in the control byte, and reads the control byte back to confirm the write.
- Used as a hardware stand-in for firmware in bring-up and in the video test harness.

---
 rtl/tqv_stage_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_tqv_stage_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqv_stage_loader.sv
// tqv_stage_loader
//   Bus initiator for the TinyQV peripheral register interface. Buffers up to
//   NUM_WORDS 32-bit object-table words from a producer. On every rising edge
//   of the peripheral interrupt it writes the whole table to byte addresses
//   0,4,..,4*(NUM_WORDS-1), writes CTRL_VALUE to CONTROL_ADDR, then reads the
//   control byte back to confirm STAGING_READY (bit1).
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   ld_valid/ld_ready   producer handshake, ld_data is the word
//   clear               empties the buffer (IDLE only, beats a same-cycle load)
//   irq                 peripheral user_interrupt, rising edge triggers a frame
//   address, wdata      peripheral address / data_in (hold while bus idle)
//   data_write_n        11 idle, 10 32-bit write, 00 8-bit write
//   data_read_n         11 idle, 00 8-bit read
//   rdata, data_ready   peripheral data_out and read acknowledge
//   busy                not IDLE
//   done                one-cycle pulse when a frame update completes
//   err                 sticky: [0] underrun, [1] overrun, [2] readback fail
//   clr_err             clears err (a same-cycle new error still sets)
//   frame_cnt           completed updates, wraps
module tqv_stage_loader #(
  parameter int          NUM_WORDS    = 4,
  parameter logic [5:0]  CONTROL_ADDR = 6'd63,
  parameter logic [7:0]  CTRL_VALUE   = 8'h02,
  parameter int          TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        clear,
  input  logic        irq,
  output logic [5:0]  address,
  output logic [31:0] wdata,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] rdata,
  input  logic        data_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err,
  input  logic        clr_err,
  output logic [15:0] frame_cnt
);

  localparam logic [3:0] NW       = 4'(NUM_WORDS);
  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);
  localparam int         TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_GAP,
    S_CTRL,
    S_CTRL_GAP,
    S_RD
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     count_q, count_d;
  logic [3:0]     idx_q, idx_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [5:0]     addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [1:0]     wn_q, wn_d;
  logic [1:0]     rn_q, rn_d;
  logic           done_q, done_d;
  logic [2:0]     err_q, err_d;
  logic [2:0]     err_set;
  logic [15:0]    frame_q, frame_d;
  logic           irq_d_q;
  logic           trig;
  logic           ld_fire;
  logic           clear_idle;

  // Full 16-entry array so the 4-bit index selects without truncation;
  // entries at or above NUM_WORDS are never written or read.
  logic [31:0]    buf_q [16];

  assign trig       = irq && !irq_d_q;
  assign ld_ready   = (state_q == S_IDLE) && (count_q < NW);
  assign ld_fire    = ld_valid && ld_ready;
  assign clear_idle = (state_q == S_IDLE) && clear;

  assign address      = addr_q;
  assign wdata        = wdata_q;
  assign data_write_n = wn_q;
  assign data_read_n  = rn_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign frame_cnt    = frame_q;

  always_ff @(posedge clk) begin
    if (ld_fire && !clear_idle) begin
      buf_q[count_q] <= ld_data;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear_idle) begin
      count_d = '0;
    end else if (ld_fire) begin
      count_d = count_q + 4'd1;
    end
  end

  // Bus outputs are registered from the next state, so a strobe is visible
  // for exactly the cycle the FSM sits in WR/CTRL and never glitches.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wn_d    = 2'b11;
    rn_d    = 2'b11;
    done_d  = 1'b0;
    frame_d = frame_q;
    err_set = '0;

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          if (count_q == NW) begin
            state_d = S_WR;
            idx_d   = '0;
            addr_d  = '0;
            wdata_d = buf_q[0];
            wn_d    = 2'b10;
          end else begin
            err_set[0] = 1'b1;
          end
        end
      end
      S_WR: begin
        state_d = S_WR_GAP;
      end
      S_WR_GAP: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_CTRL;
          addr_d  = CONTROL_ADDR;
          wdata_d = {24'b0, CTRL_VALUE};
          wn_d    = 2'b00;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_WR;
          addr_d  = {idx_d, 2'b00};
          wdata_d = buf_q[idx_d];
          wn_d    = 2'b10;
        end
      end
      S_CTRL: begin
        state_d = S_CTRL_GAP;
      end
      S_CTRL_GAP: begin
        state_d = S_RD;
        addr_d  = CONTROL_ADDR;
        rn_d    = 2'b00;
        tmo_d   = '0;
      end
      S_RD: begin
        if (data_ready) begin
          if (rdata[1] != CTRL_VALUE[1]) begin
            err_set[2] = 1'b1;
          end
          done_d  = 1'b1;
          frame_d = frame_q + 16'd1;
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_set[2] = 1'b1;
          done_d  = 1'b1;
          frame_d = frame_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          rn_d  = 2'b00;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (trig && (state_q != S_IDLE)) begin
      err_set[1] = 1'b1;
    end

    err_d = (clr_err ? 3'b000 : err_q) | err_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wn_q    <= 2'b11;
      rn_q    <= 2'b11;
      done_q  <= 1'b0;
      err_q   <= '0;
      frame_q <= '0;
      irq_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wn_q    <= wn_d;
      rn_q    <= rn_d;
      done_q  <= done_d;
      err_q   <= err_d;
      frame_q <= frame_d;
      irq_d_q <= irq;
    end
  end

endmodule

// File: tb/tb_tqv_stage_loader.sv
// Testbench for tqv_stage_loader: randomized frames checked cycle by cycle
// against the expected bus timeline derived from the frame latency rules.
module tb_tqv_stage_loader;

  localparam int N       = 4;
  localparam int TIMEOUT = 255;
  localparam int NO_ACK  = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        clear;
  logic        irq;
  logic [5:0]  address;
  logic [31:0] wdata;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] rdata;
  logic        data_ready;
  logic        busy;
  logic        done;
  logic [2:0]  err;
  logic        clr_err;
  logic [15:0] frame_cnt;

  tqv_stage_loader #(
    .NUM_WORDS   (N),
    .CONTROL_ADDR(6'd63),
    .CTRL_VALUE  (8'h02),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .clear       (clear),
    .irq         (irq),
    .address     (address),
    .wdata       (wdata),
    .data_write_n(data_write_n),
    .data_read_n (data_read_n),
    .rdata       (rdata),
    .data_ready  (data_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .clr_err     (clr_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // reference model state
  logic [31:0] m_words[$];
  logic [2:0]  m_err;
  logic [15:0] m_frames;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = w;
    check_eq("ld_ready", 64'(ld_ready), 64'(m_words.size() < N));
    @(negedge clk);
    ld_valid = 1'b0;
    if (m_words.size() < N) m_words.push_back(w);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear    = 1'b1;
    ld_valid = 1'b1;
    ld_data  = $urandom;
    @(negedge clk);
    clear    = 1'b0;
    ld_valid = 1'b0;
    m_words.delete();
    check_eq("clear_ready", 64'(ld_ready), 64'(1));
  endtask

  task automatic do_clr_err();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_err   = 3'b000;
    check_eq("clr_err", 64'(err), 64'(m_err));
  endtask

  // delay: number of read cycles before the peripheral acks (>=TIMEOUT: never)
  // rst_at: sample index at which rst_n is pulsed, -1 for none
  task automatic run_frame(input int delay, input logic [31:0] rval,
                           input bit overrun, input int rst_at, input bit clr_same);
    int ack_len;
    int done_k;
    int rdc;
    logic [1:0] exp_wn;
    logic [1:0] exp_rn;
    @(negedge clk);
    irq = 1'b1;
    if (m_words.size() != N) begin
      if (clr_same) begin
        clr_err = 1'b1;
        m_err   = 3'b001;
      end else begin
        m_err[0] = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        irq     = 1'b0;
        clr_err = 1'b0;
        check_eq("under_bus", 64'({data_write_n, data_read_n, busy, done}),
                 64'({2'b11, 2'b11, 1'b0, 1'b0}));
      end
      check_eq("under_err", 64'(err), 64'(m_err));
      return;
    end

    ack_len = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
    done_k  = 2 * N + 2 + ack_len;
    rdc     = 0;
    for (int k = 0; k <= done_k; k++) begin
      @(negedge clk);
      exp_wn = (k < 2 * N && k % 2 == 0) ? 2'b10 : (k == 2 * N) ? 2'b00 : 2'b11;
      exp_rn = (k >= 2 * N + 2 && k < done_k) ? 2'b00 : 2'b11;
      check_eq($sformatf("bus_k%0d", k), 64'({data_write_n, data_read_n, busy, done}),
               64'({exp_wn, exp_rn, 1'(k < done_k), 1'(k == done_k)}));
      if (exp_wn == 2'b10)
        check_eq($sformatf("wr_k%0d", k), {26'b0, address, wdata},
                 {26'b0, 6'(4 * (k / 2)), m_words[k / 2]});
      if (exp_wn == 2'b00)
        check_eq("ctrl_wr", {26'b0, address, wdata}, {26'b0, 6'd63, 32'h02});
      if (k == 2 * N + 2)
        check_eq("rd_addr", 64'(address), 64'(63));

      if (k == rst_at) begin
        rst_n = 1'b0;
        irq   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_words.delete();
        m_err    = 3'b000;
        m_frames = 16'd0;
        check_eq("rst_mid", 64'({data_write_n, data_read_n, busy, done, ld_ready, err, frame_cnt}),
                 64'({2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 3'b000, 16'd0}));
        return;
      end

      // peripheral read model
      if (data_read_n == 2'b00) begin
        if (rdc == delay) begin
          data_ready = 1'b1;
          rdata      = rval;
        end else begin
          data_ready = 1'b0;
          rdata      = $urandom;
        end
        rdc++;
      end else begin
        data_ready = 1'b0;
      end

      if (k == 0) irq = 1'b0;
      if (overrun && k == 4) begin
        irq      = 1'b1;
        m_err[1] = 1'b1;
      end
      if (k == 5) irq = 1'b0;

      if (k == done_k) begin
        m_frames = m_frames + 16'd1;
        if (delay >= TIMEOUT || rval[1] == 1'b0) m_err[2] = 1'b1;
        check_eq("frame_err", 64'(err), 64'(m_err));
        check_eq("frame_cnt", 64'(frame_cnt), 64'(m_frames));
      end
    end
    data_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    clear      = 1'b0;
    irq        = 1'b0;
    rdata      = '0;
    data_ready = 1'b0;
    clr_err    = 1'b0;
    m_err      = '0;
    m_frames   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset", {address, wdata, data_write_n, data_read_n, busy, done, ld_ready, err, frame_cnt},
             {6'd0, 32'd0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 3'b000, 16'd0});

    // directed: four known words, ack after 2 read cycles
    push(32'h11111111);
    push(32'h22222222);
    push(32'h33333333);
    push(32'h44444444);
    run_frame(2, 32'h02, 1'b0, -1, 1'b0);
    push($urandom);  // buffer full: refused
    run_frame(int'($urandom_range(0, 10)), $urandom | 32'h2, 1'b0, -1, 1'b0);

    // underrun, then clear
    do_clear();
    for (int i = 0; i < 3; i++) push($urandom);
    run_frame(0, 32'h02, 1'b0, -1, 1'b0);
    do_clr_err();
    // clr_err in the same cycle as a new underrun: set wins
    run_frame(0, 32'h02, 1'b0, -1, 1'b0);
    run_frame(0, 32'h02, 1'b0, -1, 1'b1);
    do_clr_err();
    push($urandom);

    // overrun during WR of word 2
    run_frame(1, 32'h02, 1'b1, -1, 1'b0);
    do_clr_err();
    // readback timeout and readback mismatch
    run_frame(NO_ACK, 32'h02, 1'b0, -1, 1'b0);
    do_clr_err();
    run_frame(3, 32'h00, 1'b0, -1, 1'b0);
    do_clr_err();

    // randomized frames
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        int np;
        do_clear();
        np = int'($urandom_range(3, 6));
        for (int j = 0; j < np; j++) push($urandom);
      end
      run_frame(($urandom_range(0, 7) == 0) ? NO_ACK : int'($urandom_range(0, 12)),
                $urandom, 1'($urandom_range(0, 3) == 0), -1, 1'b0);
      if ($urandom_range(0, 1) == 1) do_clr_err();
    end

    // reset during WR_GAP of word 1, then trigger without reloading
    do_clear();
    for (int i = 0; i < N; i++) push($urandom);
    run_frame(2, 32'h02, 1'b0, 3, 1'b0);
    run_frame(0, 32'h02, 1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
